// File: rtl/window_min_max_pkg.sv
// Shared types and width helpers for the windowed min/max stage.
package window_min_max_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int count_width(input int window);
    return $clog2(window + 1);
  endfunction

  // Index of a sample within the window; never narrower than one bit.
  function automatic int idx_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/window_min_max_if.sv
// Sample-in / result-out handshake bundle for window_min_max.
// MINMAX_INDEX_EN adds the first-occurrence index outputs.
interface window_min_max_if
  import window_min_max_pkg::*;
#(
  parameter int N      = 8,
  parameter int WINDOW = 4
);
  localparam int IDX_W = idx_width(WINDOW);

  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         clear;
  logic [N-1:0] out_min;
  logic [N-1:0] out_max;
  logic         out_valid;
  logic         out_ready;
`ifdef MINMAX_INDEX_EN
  logic [IDX_W-1:0] out_min_idx;
  logic [IDX_W-1:0] out_max_idx;

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_min, out_max, out_valid, out_min_idx, out_max_idx
  );
  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_min, out_max, out_valid, out_min_idx, out_max_idx
  );
`else
  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_min, out_max, out_valid
  );
  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_min, out_max, out_valid
  );
`endif

endinterface

// File: rtl/less_than.sv
// Unsigned comparator: out = (a < b), taken from the borrow of a - b.
module less_than #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         out
);
  logic [N:0] diff;

  assign diff = {1'b0, a} - {1'b0, b};
  assign sum  = diff[N-1:0];
  assign out  = diff[N];

endmodule

// File: rtl/window_min_max.sv
// Tracks min/max over each window of WINDOW samples and holds the result until consumed.
// Optional MINMAX_INDEX_EN also reports the first-occurrence position of min and max.
module window_min_max
  import window_min_max_pkg::*;
#(
  parameter int N      = 8,
  parameter int WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  window_min_max_if.slave  bus
);
  localparam int CNT_W = count_width(WINDOW);
  localparam int IDX_W = idx_width(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [N-1:0]     min_r, min_next, max_r, max_next;
  logic [N-1:0]     out_min_r, out_min_next, out_max_r, out_max_next;
  logic             min_lt, max_lt, accept;
  logic [N-1:0]     upd_min, upd_max;

  less_than #(.N(N)) lt_min (.a(bus.in_data), .b(min_r), .sum(), .out(min_lt));
  less_than #(.N(N)) lt_max (.a(max_r), .b(bus.in_data), .sum(), .out(max_lt));

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_min   = out_min_r;
  assign bus.out_max   = out_max_r;

  // clear wins over a simultaneous offer; in DONE in_ready is already low.
  assign accept  = bus.in_valid && bus.in_ready && !bus.clear;
  assign upd_min = min_lt ? bus.in_data : min_r;
  assign upd_max = max_lt ? bus.in_data : max_r;

`ifdef MINMAX_INDEX_EN
  logic [IDX_W-1:0] min_idx, min_idx_next, max_idx, max_idx_next;
  logic [IDX_W-1:0] out_min_idx_r, out_min_idx_next, out_max_idx_r, out_max_idx_next;
  logic [IDX_W-1:0] upd_min_idx, upd_max_idx;

  assign upd_min_idx     = min_lt ? IDX_W'(count) : min_idx;
  assign upd_max_idx     = max_lt ? IDX_W'(count) : max_idx;
  assign bus.out_min_idx = out_min_idx_r;
  assign bus.out_max_idx = out_max_idx_r;
`endif

  // NOTE: every next-value gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    count_next   = count;
    min_next     = min_r;
    max_next     = max_r;
    out_min_next = out_min_r;
    out_max_next = out_max_r;
`ifdef MINMAX_INDEX_EN
    min_idx_next     = min_idx;
    max_idx_next     = max_idx;
    out_min_idx_next = out_min_idx_r;
    out_max_idx_next = out_max_idx_r;
`endif
    unique case (state)
      IDLE: begin
        if (bus.clear) begin
          count_next = '0;
        end else if (accept) begin
          min_next   = bus.in_data;
          max_next   = bus.in_data;
          count_next = CNT_W'(1);
`ifdef MINMAX_INDEX_EN
          min_idx_next = '0;
          max_idx_next = '0;
`endif
          if (WINDOW == 1) begin
            state_next   = DONE;
            out_min_next = bus.in_data;
            out_max_next = bus.in_data;
`ifdef MINMAX_INDEX_EN
            out_min_idx_next = '0;
            out_max_idx_next = '0;
`endif
          end else begin
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (bus.clear) begin
          state_next = IDLE;
          count_next = '0;
        end else if (accept) begin
          min_next   = upd_min;
          max_next   = upd_max;
          count_next = count + CNT_W'(1);
`ifdef MINMAX_INDEX_EN
          min_idx_next = upd_min_idx;
          max_idx_next = upd_max_idx;
`endif
          if (count == LAST) begin
            state_next   = DONE;
            out_min_next = upd_min;
            out_max_next = upd_max;
`ifdef MINMAX_INDEX_EN
            out_min_idx_next = upd_min_idx;
            out_max_idx_next = upd_max_idx;
`endif
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      min_r     <= '0;
      max_r     <= '0;
      out_min_r <= '0;
      out_max_r <= '0;
`ifdef MINMAX_INDEX_EN
      min_idx       <= '0;
      max_idx       <= '0;
      out_min_idx_r <= '0;
      out_max_idx_r <= '0;
`endif
    end else begin
      state     <= state_next;
      count     <= count_next;
      min_r     <= min_next;
      max_r     <= max_next;
      out_min_r <= out_min_next;
      out_max_r <= out_max_next;
`ifdef MINMAX_INDEX_EN
      min_idx       <= min_idx_next;
      max_idx       <= max_idx_next;
      out_min_idx_r <= out_min_idx_next;
      out_max_idx_r <= out_max_idx_next;
`endif
    end
  end

endmodule

// File: tb/tb_window_min_max.sv
// Directed bench: WINDOW=4 instance (dut) and WINDOW=1 instance (dut1) sharing clk/rst_n.
module tb_window_min_max;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  window_min_max_if #(.N(8), .WINDOW(4)) bus ();
  window_min_max_if #(.N(8), .WINDOW(1)) bus1 ();

  window_min_max #(.N(8), .WINDOW(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  window_min_max #(.N(8), .WINDOW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample for a single edge; the DUT must be ready for it.
  task automatic send(input bit one, input logic [7:0] d);
    if (one) begin
      check("ready_before_send1", 32'(bus1.in_ready), 32'd1);
      bus1.in_data = d; bus1.in_valid = 1'b1;
      step();
      bus1.in_valid = 1'b0;
    end else begin
      check("ready_before_send", 32'(bus.in_ready), 32'd1);
      bus.in_data = d; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] mn, input logic [7:0] mx,
                              input int mni, input int mxi);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_min"},   32'(bus.out_min),   32'(mn));
    check({tag, "_max"},   32'(bus.out_max),   32'(mx));
    check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
`ifdef MINMAX_INDEX_EN
    check({tag, "_min_idx"}, 32'(bus.out_min_idx), 32'(mni));
    check({tag, "_max_idx"}, 32'(bus.out_max_idx), 32'(mxi));
`else
    if (mni < 0 || mxi < 0) check({tag, "_idx_arg"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    bus.in_data = '0;  bus.in_valid = 1'b0;  bus.clear = 1'b0;  bus.out_ready = 1'b1;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.clear = 1'b0; bus1.out_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_min",   32'(bus.out_min),   32'd0);
    check("rst_max",   32'(bus.out_max),   32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 5,2,9,7 with out_ready high
    send(0, 8'd5); send(0, 8'd2); send(0, 8'd9);
    check("w1_not_yet", 32'(bus.out_valid), 32'd0);
    send(0, 8'd7);
    check_result("w1", 8'd2, 8'd9, 1, 2);
    step();
    check("w1_consumed", 32'(bus.out_valid), 32'd0);
    check("w1_ready_back", 32'(bus.in_ready), 32'd1);

    // Extremes with back-pressure held for 3 cycles
    bus.out_ready = 1'b0;
    send(0, 8'hFF); send(0, 8'h00); send(0, 8'h80); send(0, 8'h7F);
    check_result("w2", 8'h00, 8'hFF, 1, 0);
    bus.in_data = 8'h11; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_result("w2_hold", 8'h00, 8'hFF, 1, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("w2_released", 32'(bus.out_valid), 32'd0);
    check("w2_ready_back", 32'(bus.in_ready), 32'd1);

    // Ties keep the first occurrence
    for (int i = 0; i < 4; i++) send(0, 8'd3);
    check_result("ties", 8'd3, 8'd3, 0, 0);
    step();

    // Clear beats a concurrent offer
    send(0, 8'd4); send(0, 8'd6);
    bus.clear = 1'b1; bus.in_data = 8'd1; bus.in_valid = 1'b1;
    step();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);
    send(0, 8'd8); send(0, 8'd8); send(0, 8'd8);
    check("clr_not_yet", 32'(bus.out_valid), 32'd0);
    send(0, 8'd8);
    check_result("clr", 8'd8, 8'd8, 0, 0);
    step();

    // Reset mid-window discards partial state
    send(0, 8'd6); send(0, 8'd0);
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3);
    check("midrst_not_yet", 32'(bus.out_valid), 32'd0);
    send(0, 8'd4);
    check_result("midrst", 8'd1, 8'd4, 0, 3);
    step();

    // WINDOW=1: every sample is a window
    send(1, 8'd10);
    check("w1x_valid", 32'(bus1.out_valid), 32'd1);
    check("w1x_min",   32'(bus1.out_min),   32'd10);
    check("w1x_max",   32'(bus1.out_max),   32'd10);
    check("w1x_ready", 32'(bus1.in_ready),  32'd0);
    step();
    check("w1x_gone", 32'(bus1.out_valid), 32'd0);
    send(1, 8'd20);
    check("w1y_valid", 32'(bus1.out_valid), 32'd1);
    check("w1y_min",   32'(bus1.out_min),   32'd20);
    check("w1y_max",   32'(bus1.out_max),   32'd20);
    check("w1y_ready", 32'(bus1.in_ready),  32'd0);
`ifdef MINMAX_INDEX_EN
    check("w1y_min_idx", 32'(bus1.out_min_idx), 32'd0);
    check("w1y_max_idx", 32'(bus1.out_max_idx), 32'd0);
`endif
    step();
    check("w1y_gone", 32'(bus1.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
